// File: rtl/program_launcher.sv
// program_launcher: runs a batch of programs on a processor under test.
// Each batch is one reset phase, then a start pulse and ack wait per program.
module program_launcher #(
  parameter int unsigned RST_CYC     = 2,
  parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Go,
  input  logic [2:0]  NumProgs,
  output logic        DutReset,
  output logic        DutStart,
  input  logic        DutAck,
  output logic        Busy,
  output logic        Done,
  output logic        TimedOut,
  output logic [2:0]  ProgIdx,
  output logic        ProgDone,
  output logic [15:0] CycleCount
);

  localparam int unsigned IDX_W = 3;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned RST_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RST    = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [RST_W-1:0] rst_cnt, rst_cnt_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt, wait_now;
  logic             arm, arm_nxt;
  logic [IDX_W-1:0] num_progs, num_progs_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic             timed_nxt;
  logic [CNT_W-1:0] cc_nxt;
  logic             pdone_nxt;

  // Next-state and next-output logic; every register holds unless changed below.
  always_comb begin
    state_nxt     = state;
    rst_cnt_nxt   = rst_cnt;
    wait_cnt_nxt  = wait_cnt;
    arm_nxt       = arm;
    num_progs_nxt = num_progs;
    idx_nxt       = ProgIdx;
    timed_nxt     = TimedOut;
    cc_nxt        = CycleCount;
    pdone_nxt     = 1'b0;
    wait_now      = wait_cnt + CNT_W'(1);

    unique case (state)
      S_IDLE, S_FINISH: begin
        if (Go) begin
          timed_nxt = 1'b0;
          if (NumProgs == '0) begin
            state_nxt = S_FINISH;
          end else begin
            state_nxt     = S_RST;
            num_progs_nxt = NumProgs;
            idx_nxt       = '0;
            rst_cnt_nxt   = '0;
          end
        end
      end
      S_RST: begin
        if (rst_cnt == RST_LAST) state_nxt = S_START;
        else                     rst_cnt_nxt = rst_cnt + RST_W'(1);
      end
      S_START: begin
        wait_cnt_nxt = '0;
        arm_nxt      = 1'b0;
        state_nxt    = S_WAIT;
      end
      S_WAIT: begin
        wait_cnt_nxt = wait_now;
        // A low Ack proves the previous program's done flag has been released.
        if (!DutAck) arm_nxt = 1'b1;
        if (DutAck && arm) begin
          cc_nxt    = wait_now;
          pdone_nxt = 1'b1;
          if (ProgIdx == IDX_W'(num_progs - IDX_W'(1))) begin
            state_nxt = S_FINISH;
          end else begin
            idx_nxt   = ProgIdx + IDX_W'(1);
            state_nxt = S_START;
          end
        end else if (wait_now == TIMEOUT_CYC) begin
          timed_nxt = 1'b1;
          cc_nxt    = TIMEOUT_CYC;
          state_nxt = S_FINISH;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State and output registers; phase outputs are decoded from the next state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= S_IDLE;
      rst_cnt    <= '0;
      wait_cnt   <= '0;
      arm        <= 1'b0;
      num_progs  <= '0;
      DutReset   <= 1'b1;
      DutStart   <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      TimedOut   <= 1'b0;
      ProgIdx    <= '0;
      ProgDone   <= 1'b0;
      CycleCount <= '0;
    end else begin
      state      <= state_nxt;
      rst_cnt    <= rst_cnt_nxt;
      wait_cnt   <= wait_cnt_nxt;
      arm        <= arm_nxt;
      num_progs  <= num_progs_nxt;
      DutReset   <= (state_nxt == S_RST);
      DutStart   <= (state_nxt == S_START);
      Busy       <= (state_nxt == S_RST) || (state_nxt == S_START) || (state_nxt == S_WAIT);
      Done       <= (state_nxt == S_FINISH);
      TimedOut   <= timed_nxt;
      ProgIdx    <= idx_nxt;
      ProgDone   <= pdone_nxt;
      CycleCount <= cc_nxt;
    end
  end

endmodule

// File: tb/tb_program_launcher.sv
// Bench for program_launcher: directed scenario table, reset-abort sequence and
// random batches, all checked cycle by cycle against a trace built from the rules.
module tb_program_launcher;

  localparam int RST_N = 2;
  localparam int TMO   = 20;
  localparam int NG    = 255;

  logic        Clk = 1'b0;
  logic        Reset, Go, DutAck;
  logic [2:0]  NumProgs;
  logic        DutReset, DutStart, Busy, Done, TimedOut, ProgDone;
  logic [2:0]  ProgIdx;
  logic [15:0] CycleCount;

  program_launcher #(.RST_CYC(RST_N), .TIMEOUT_CYC(16'(TMO))) dut (
    .Clk(Clk), .Reset(Reset), .Go(Go), .NumProgs(NumProgs),
    .DutReset(DutReset), .DutStart(DutStart), .DutAck(DutAck),
    .Busy(Busy), .Done(Done), .TimedOut(TimedOut), .ProgIdx(ProgIdx),
    .ProgDone(ProgDone), .CycleCount(CycleCount)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic        rst, start, busy, done, pdone, timed;
    logic [2:0]  idx;
    logic [15:0] cc;
  } out_t;

  typedef struct packed {
    logic [2:0]      n;
    logic [2:0][7:0] stale;
    logic [2:0][7:0] lat;
    logic [7:0]      glitch;
    logic [3:0]      exp_starts, exp_pdones, exp_rst;
    logic [15:0]     exp_cc;
    logic            exp_timed;
  } vec_t;

  int   checks = 0, errors = 0;
  out_t exp_q[$];
  int   pat_s[8], pat_l[8];
  int   prog_seen, since, cur;
  int   m_cc, m_idx;
  logic m_timed;
  int   n_starts, n_pdones, n_rst;

  function automatic out_t sample();
    out_t o;
    o.rst = DutReset; o.start = DutStart; o.busy = Busy; o.done = Done;
    o.pdone = ProgDone; o.timed = TimedOut; o.idx = ProgIdx; o.cc = CycleCount;
    return o;
  endfunction

  function automatic string fmt(out_t o);
    return $sformatf("rst=%0b start=%0b busy=%0b done=%0b pdone=%0b to=%0b idx=%0d cc=%0d",
                     o.rst, o.start, o.busy, o.done, o.pdone, o.timed, o.idx, o.cc);
  endfunction

  function automatic out_t mk_out(logic rst, logic start, logic busy, logic done,
                                  logic pdone, logic timed, int idx, int cc);
    out_t o;
    o.rst = rst; o.start = start; o.busy = busy; o.done = done;
    o.pdone = pdone; o.timed = timed; o.idx = 3'(idx); o.cc = 16'(cc);
    return o;
  endfunction

  function automatic vec_t mk_vec(int n, int s0, int s1, int s2, int l0, int l1, int l2,
                                  int g, int es, int ep, int er, int cc, logic to);
    vec_t v;
    v.n = 3'(n);
    v.stale[0] = 8'(s0); v.stale[1] = 8'(s1); v.stale[2] = 8'(s2);
    v.lat[0] = 8'(l0); v.lat[1] = 8'(l1); v.lat[2] = 8'(l2);
    v.glitch = 8'(g);
    v.exp_starts = 4'(es); v.exp_pdones = 4'(ep); v.exp_rst = 4'(er);
    v.exp_cc = 16'(cc); v.exp_timed = to;
    return v;
  endfunction

  // Ack pattern relative to Start (n=0): high while n < s, low, then high from n >= l.
  // Accepted at the first WAIT cycle with Ack high after some earlier WAIT cycle saw it low.
  function automatic int accept_at(int s, int l);
    logic seen_low;
    logic a;
    seen_low = 1'b0;
    for (int n = 1; n <= TMO; n++) begin
      a = (n < s) || (n >= l);
      if (a && seen_low) return n;
      if (!a) seen_low = 1'b1;
    end
    return 0;
  endfunction

  // Expected output trace, one entry per cycle after the Go edge.
  task automatic build_expect(input int n);
    int   k, w;
    logic pd;
    exp_q.delete();
    m_timed = 1'b0;
    if (n != 0) begin
      m_idx = 0;
      pd    = 1'b0;
      repeat (RST_N) exp_q.push_back(mk_out(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, m_cc));
      for (int p = 0; p < n; p++) begin
        m_idx = p;
        exp_q.push_back(mk_out(1'b0, 1'b1, 1'b1, 1'b0, pd, 1'b0, p, m_cc));
        k = accept_at(pat_s[p], pat_l[p]);
        w = (k != 0) ? k : TMO;
        for (int i = 1; i <= w; i++)
          exp_q.push_back(mk_out(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, p, m_cc));
        if (k != 0) begin
          m_cc = k;
          pd   = 1'b1;
        end else begin
          m_cc    = TMO;
          m_timed = 1'b1;
          pd      = 1'b0;
          break;
        end
      end
      exp_q.push_back(mk_out(1'b0, 1'b0, 1'b0, 1'b1, pd, m_timed, m_idx, m_cc));
    end
    repeat (3) exp_q.push_back(mk_out(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, m_timed, m_idx, m_cc));
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_out(input string tag, input int cyc, input out_t exp);
    out_t got;
    got = sample();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d: got %s want %s", tag, cyc, fmt(got), fmt(exp));
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  // Processor model: restarts its pattern on each observed Start pulse.
  task automatic drive_ack();
    if (DutStart) begin
      cur = (prog_seen < 8) ? prog_seen : 7;
      prog_seen++;
      since = 0;
    end else begin
      since++;
    end
    if (prog_seen > 0) DutAck = (since < pat_s[cur]) || (since >= pat_l[cur]);
  endtask

  task automatic run_batch(input string tag, input int n, input int glitch);
    out_t got;
    build_expect(n);
    n_starts = 0; n_pdones = 0; n_rst = 0;
    prog_seen = 0; since = 0; cur = 0;
    Go = 1'b1;
    NumProgs = 3'(n);
    step();
    Go = 1'b0;
    NumProgs = 3'($urandom_range(0, 7));
    for (int i = 0; i < exp_q.size(); i++) begin
      got = sample();
      n_starts += int'(got.start);
      n_pdones += int'(got.pdone);
      n_rst    += int'(got.rst);
      check_out(tag, i, exp_q[i]);
      drive_ack();
      if (i == glitch && exp_q[i].busy) begin
        Go = 1'b1;
        NumProgs = 3'd7;
      end else begin
        Go = 1'b0;
      end
      step();
    end
    Go = 1'b0;
  endtask

  initial begin
    vec_t tbl[9];
    int   g, n;
    logic found;
    out_t zero_o, rst_o;

    tbl[0] = mk_vec(1, 0, 0, 0,  10,   0, 0, NG, 1, 1, 2, 10, 1'b0); // single program
    tbl[1] = mk_vec(1, 2, 0, 0,   5,   0, 0, NG, 1, 1, 2,  5, 1'b0); // stale ack
    tbl[2] = mk_vec(3, 0, 0, 0,   4,   7, 9, NG, 3, 3, 2,  9, 1'b0); // batch 4/7/9
    tbl[3] = mk_vec(1, 0, 0, 0, 255,   0, 0, NG, 1, 0, 2, 20, 1'b1); // timeout
    tbl[4] = mk_vec(0, 0, 0, 0,   0,   0, 0, NG, 0, 0, 0, 20, 1'b0); // zero programs
    tbl[5] = mk_vec(1, 0, 0, 0,   6,   0, 0, NG, 1, 1, 2,  6, 1'b0); // recover
    tbl[6] = mk_vec(1, 0, 0, 0,  20,   0, 0, NG, 1, 1, 2, 20, 1'b0); // ack at timeout
    tbl[7] = mk_vec(1, 0, 0, 0,  12,   0, 0,  6, 1, 1, 2, 12, 1'b0); // Go during WAIT
    tbl[8] = mk_vec(3, 0, 0, 0,   3, 255, 4,  0, 2, 1, 2, 20, 1'b1); // timeout mid batch

    zero_o = mk_out(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    rst_o  = mk_out(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

    Reset = 1'b1; Go = 1'b0; NumProgs = 3'd0; DutAck = 1'b0;
    prog_seen = 0; since = 0; cur = 0;
    m_cc = 0; m_idx = 0; m_timed = 1'b0;
    for (int p = 0; p < 8; p++) begin pat_s[p] = 0; pat_l[p] = NG; end

    for (int i = 0; i < 3; i++) begin
      step();
      check_out("reset", i, rst_o);
    end
    Reset = 1'b0;
    step();
    check_out("idle", 0, zero_o);

    for (int t = 0; t < 9; t++) begin
      for (int p = 0; p < 8; p++) begin
        pat_s[p] = (p < 3) ? int'(tbl[t].stale[p]) : 0;
        pat_l[p] = (p < 3) ? int'(tbl[t].lat[p]) : NG;
      end
      g = (tbl[t].glitch == 8'(NG)) ? -1 : int'(tbl[t].glitch);
      run_batch($sformatf("vec%0d", t), int'(tbl[t].n), g);
      check_int($sformatf("vec%0d starts", t), n_starts, int'(tbl[t].exp_starts));
      check_int($sformatf("vec%0d progdone", t), n_pdones, int'(tbl[t].exp_pdones));
      check_int($sformatf("vec%0d dutreset", t), n_rst, int'(tbl[t].exp_rst));
      check_int($sformatf("vec%0d cyclecount", t), int'(CycleCount), int'(tbl[t].exp_cc));
      check_int($sformatf("vec%0d timedout", t), int'(TimedOut), int'(tbl[t].exp_timed));
    end

    // Reset during WAIT of the second program of three aborts the batch.
    for (int p = 0; p < 8; p++) begin pat_s[p] = 0; pat_l[p] = NG; end
    pat_l[0] = 4; pat_l[1] = 30; pat_l[2] = 5;
    prog_seen = 0; since = 0; cur = 0;
    Go = 1'b1; NumProgs = 3'd3;
    step();
    Go = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      drive_ack();
      if (DutStart && ProgIdx == 3'd1) found = 1'b1;
      else step();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL abort: second Start not seen within 60 cycles");
    end
    for (int i = 0; i < 3; i++) begin step(); drive_ack(); end
    Reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check_out("abort_reset", i, rst_o);
    end
    Reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      drive_ack();
      check_out("abort_idle", i, zero_o);
    end
    m_cc = 0; m_idx = 0; m_timed = 1'b0;

    for (int r = 0; r < 30; r++) begin
      n = int'($urandom_range(0, 7));
      for (int p = 0; p < 8; p++) begin
        pat_s[p] = int'($urandom_range(0, 3));
        pat_l[p] = int'($urandom_range(1, 24));
      end
      run_batch($sformatf("rand%0d", r), n, int'($urandom_range(0, 80)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
